chunk_addsub: RTL and testbench
===============================

// Module: chunk_addsub
// PURPOSE
//  Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair
//  CHUNK bits per clock, LSB chunk first, through a registered carry.
//  Successor to the team's 8-bit ripple-carry adder: arbitrary width, add/sub mode,
//  start/busy/done handshake and signed-overflow flag.
//  Sits between operand registers and the datapath result bus.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >= 2
//  CHUNK  4   bits added per clock; WIDTH % CHUNK must be 0, else elaboration $error
// PORTS
//  clk    in   1      single clock, all state updates on rising edge
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; accepted only when state is IDLE or DONE
//  sub    in   1      0: A+B+cin, 1: A-B-cin (sampled with start)
//  a_in   in   WIDTH  operand A (sampled with start)
//  b_in   in   WIDTH  operand B (sampled with start)
//  cin    in   1      carry-in / borrow-in (sampled with start)
//  busy   out  1      high while chunks are being processed
//  done   out  1      one-cycle pulse: result valid and updated
//  sum    out  WIDTH  result, held until next completion
//  cout   out  1      carry-out; in sub mode 1 = no borrow
//  ovf    out  1      signed (two's complement) overflow of last result
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0;
//    working registers cleared. Reset mid-operation abandons it, no done pulse.
//  - NCH = WIDTH/CHUNK. States: IDLE -> RUN -> DONE -> (IDLE | RUN).
//  - IDLE: busy=0, done=0. start=1 at edge -> RUN; latch a_in, b_in^{WIDTH{sub}},
//    carry=cin^sub, chunk counter=0.
//  - RUN: busy=1. Each edge adds chunk k of A, B' and carry; writes chunk k of
//    working sum; updates carry; k++. start ignored (no queueing).
//    At the edge processing k=NCH-1: sum<=working result, cout<=final carry,
//    ovf<=carry_into_MSB ^ carry_out_of_MSB, state->DONE.
//  - DONE: done=1, busy=0 for exactly one cycle. start=1 -> RUN (back-to-back,
//    operands latched as in IDLE); else -> IDLE.
//  - Latency: start sampled at edge E0 -> busy high cycles 1..NCH, done and new
//    sum/cout/ovf visible in cycle NCH+1. Throughput: one op per NCH+1 cycles.
//  - CHUNK==WIDTH: NCH=1, single RUN cycle.
//  - sum/cout/ovf only change at completion or reset; stable during RUN.
//  - Arithmetic mod 2^WIDTH; carry is 1 bit between chunks, never wider.
// CONFIGURATION
//  CHUNK_ADDSUB_SAT_EN defined: on ovf=1 sum is clamped to signed limit
//    (0111..1 if result should be positive, 1000..0 if negative); ovf still 1;
//    cout unchanged. Decision from sign of A and B' at completion.
//  Not defined: sum wraps modulo 2^WIDTH; ovf reported only.
// TESTING (WIDTH=16, CHUNK=4 unless stated)
//  1 rst=1 two cycles, then idle -> busy=0 done=0 sum=0x0000 cout=0 ovf=0.
//  2 add 0x1234+0x0FFF cin=0 -> busy cycles 1-4, done cycle 5, sum=0x2233 cout=0 ovf=0.
//  3 sub 0x0005-0x0007 cin=0 -> sum=0xFFFE cout=0 ovf=0; 0xFFFF+0x0000 cin=1 ->
//    sum=0x0000 cout=1 ovf=0; start pulsed during RUN ignored (one done only).
//  4 add 0x7FFF+0x0001 -> ovf=1 cout=0; sum=0x8000 (macro off) / 0x7FFF (SAT_EN);
//    sub 0x8000-0x0001 -> ovf=1, sum=0x7FFF (off) / 0x8000 (SAT_EN).
//  5 rst=1 in cycle 2 of RUN -> next cycle all outputs 0, no done; new start
//    completes normally. start held in DONE cycle -> back-to-back op, done 5 later.
//  6 WIDTH=8 CHUNK=1 and CHUNK=8: all A,B,cin,sub combos vs {cout,sum}=A+B+cin
//    (or A-B-cin), zero mismatches; error count and test count reported.

Source files
------------

// File: rtl/chunk_addsub.sv
// chunk_addsub: multi-cycle adder/subtractor. A WIDTH-bit operand pair is
// processed CHUNK bits per clock, LSB chunk first, through a 1-bit registered
// carry. Reports carry-out (1 = no borrow in sub mode) and signed overflow.
// Optional build macro CHUNK_ADDSUB_SAT_EN: clamp the result to the signed
// limit when overflow occurs. Without it the result wraps modulo 2^WIDTH.
//
// Handshake: start is accepted only in IDLE or DONE (operands, sub and cin
// are sampled on that edge); busy is high for the NCH RUN cycles; done pulses
// high for exactly one cycle when sum/cout/ovf have been updated. start seen
// during RUN is ignored, not queued. Holding start high in the DONE cycle
// launches the next operation back-to-back.
module chunk_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  // Reject configurations that cannot be split into whole chunks.
  if (WIDTH < 2) begin : g_bad_width
    $error("chunk_addsub: WIDTH must be >= 2");
  end
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunk_addsub: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // B already inverted in sub mode
  logic [WIDTH-1:0] work_q;   // partially assembled result
  logic             carry_q;
  logic [KW-1:0]    k_q;      // index of the chunk processed this cycle
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] sum_d;
  logic             last_chunk;
  logic             ovf_d;

  // Add the current chunk and form the completed result and flags.
  always_comb begin
    base       = {{(32-KW){1'b0}}, k_q} * CHUNK;
    a_chunk    = a_q[base +: CHUNK];
    b_chunk    = b_q[base +: CHUNK];
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    work_d     = work_q;
    work_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    last_chunk = (k_q == KW'(NCH - 1));
    // Same-sign operands producing a differently signed result is exactly
    // carry-into-MSB xor carry-out-of-MSB, without needing a split chunk.
    ovf_d      = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
    sum_d      = work_d;
`ifdef CHUNK_ADDSUB_SAT_EN
    // On overflow both operands share a sign; the true result has that sign.
    if (ovf_d) begin
      sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Control FSM, operand/carry registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          busy_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            a_q     <= a_in;
            b_q     <= b_in ^ {WIDTH{sub}};
            carry_q <= cin ^ sub;
            k_q     <= '0;
            work_q  <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          work_q  <= work_d;
          carry_q <= chunk_sum[CHUNK];
          k_q     <= k_q + 1'b1;
          if (last_chunk) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= sum_d;
            cout_q  <= chunk_sum[CHUNK];
            ovf_q   <= ovf_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_chunk_addsub.sv
// Testbench for chunk_addsub: directed 16-bit/4-bit vectors plus an 8-bit
// sweep on CHUNK=1 and CHUNK=8 instances, checked through expected queues.
module tb_chunk_addsub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- 16-bit / 4-bit DUT ----------------
  logic        start, sub, cin;
  logic [15:0] a_in, b_in;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;
  logic [1:0]  dbg_state;

  chunk_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a_in(a_in), .b_in(b_in),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  // ---------------- 8-bit DUTs (CHUNK=1 and CHUNK=8) ----------------
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy_c1, done_c1, cout_c1, ovf_c1;
  logic [7:0] sum_c1;
  logic [1:0] st_c1;
  logic       busy_c8, done_c8, cout_c8, ovf_c8;
  logic [7:0] sum_c8;
  logic [1:0] st_c8;

  chunk_addsub #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a_in(a8), .b_in(b8),
    .cin(cin8), .busy(busy_c1), .done(done_c1), .sum(sum_c1), .cout(cout_c1),
    .ovf(ovf_c1), .dbg_state(st_c1)
  );

  chunk_addsub #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a_in(a8), .b_in(b8),
    .cin(cin8), .busy(busy_c8), .done(done_c8), .sum(sum_c8), .cout(cout_c8),
    .ovf(ovf_c8), .dbg_state(st_c8)
  );

  // ---------------- scoreboard ----------------
  // Entries are {ovf, cout, sum}.
  logic [17:0] exp16_q[$];
  logic [9:0]  exp8_c1_q[$];
  logic [9:0]  exp8_c8_q[$];
  int n_cmp = 0;
  int n_err = 0;

`ifdef CHUNK_ADDSUB_SAT_EN
  localparam logic [15:0] OVF_ADD_SUM = 16'h7FFF;  // 0x7FFF+1 clamps high
  localparam logic [15:0] OVF_SUB_SUM = 16'h8000;  // 0x8000-1 clamps low
  localparam logic [15:0] OVF_NEG_SUM = 16'h8000;  // 0x8000+0x8000 clamps low
`else
  localparam logic [15:0] OVF_ADD_SUM = 16'h8000;
  localparam logic [15:0] OVF_SUB_SUM = 16'h7FFF;
  localparam logic [15:0] OVF_NEG_SUM = 16'h0000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop an expectation whenever a DUT presents done.
  always @(negedge clk) begin
    if (done) begin
      if (exp16_q.size() == 0) check("spurious_done16", {31'b0, done}, 32'd0);
      else check("result16", {14'b0, ovf, cout, sum}, {14'b0, exp16_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (done_c1) begin
      if (exp8_c1_q.size() == 0) check("spurious_done_c1", {31'b0, done_c1}, 32'd0);
      else check("result_c1", {22'b0, ovf_c1, cout_c1, sum_c1}, {22'b0, exp8_c1_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (done_c8) begin
      if (exp8_c8_q.size() == 0) check("spurious_done_c8", {31'b0, done_c8}, 32'd0);
      else check("result_c8", {22'b0, ovf_c8, cout_c8, sum_c8}, {22'b0, exp8_c8_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done16();
    int t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("timeout16", {31'b0, done}, 32'd1);
  endtask

  task automatic issue16(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [17:0] e);
    @(negedge clk);
    sub = s; a_in = a; b_in = b; cin = c; start = 1'b1;
    exp16_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_done16();
  endtask

  // Reference for the 8-bit sweep: 9-bit arithmetic, flags from operand signs.
  function automatic logic [9:0] model8(input logic s, input logic [7:0] a,
                                        input logic [7:0] b, input logic c);
    logic [8:0] full;
    logic [7:0] res;
    logic       co, ov;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b} + {8'b0, c};
      co   = full[8];
      ov   = (a[7] == b[7]) && (full[7] != a[7]);
    end else begin
      full = {1'b0, a} - {1'b0, b} - {8'b0, c};
      co   = ~full[8];
      ov   = (a[7] != b[7]) && (full[7] != a[7]);
    end
    res = full[7:0];
`ifdef CHUNK_ADDSUB_SAT_EN
    if (ov) res = a[7] ? 8'h80 : 8'h7F;
`endif
    return {ov, co, res};
  endfunction

  task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [9:0] e;
    int t;
    e = model8(s, a, b, c);
    @(negedge clk);
    sub8 = s; a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    exp8_c1_q.push_back(e);
    exp8_c8_q.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    t = 0;
    while (!done_c1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("timeout_c1", {31'b0, done_c1}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] vals [12];

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    vals = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0};

    // 1: reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sum", {16'b0, sum}, 32'h0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);

    // 2: latency/timing of a plain add
    @(negedge clk);
    sub = 1'b0; a_in = 16'h1234; b_in = 16'h0FFF; cin = 1'b0; start = 1'b1;
    exp16_q.push_back({1'b0, 1'b0, 16'h2233});
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("lat_busy", {31'b0, busy}, 32'd1);
      check("lat_nodone", {31'b0, done}, 32'd0);
      check("run_sum_stable", {16'b0, sum}, 32'h0);
      @(negedge clk);
    end
    check("lat_done", {31'b0, done}, 32'd1);
    check("lat_busy_off", {31'b0, busy}, 32'd0);

    // 3: subtraction, carry wrap, start pulsed during RUN
    @(negedge clk);
    sub = 1'b1; a_in = 16'h0005; b_in = 16'h0007; cin = 1'b0; start = 1'b1;
    exp16_q.push_back({1'b0, 1'b0, 16'hFFFE});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    sub = 1'b0; a_in = 16'h1111; b_in = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done16();
    repeat (8) @(negedge clk);
    issue16(1'b0, 16'hFFFF, 16'h0000, 1'b1, {1'b0, 1'b1, 16'h0000});
    issue16(1'b0, 16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000});
    issue16(1'b1, 16'h0000, 16'h0000, 1'b1, {1'b0, 1'b0, 16'hFFFF});

    // 4: signed overflow boundaries
    issue16(1'b0, 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, OVF_ADD_SUM});
    issue16(1'b1, 16'h8000, 16'h0001, 1'b0, {1'b1, 1'b1, OVF_SUB_SUM});
    issue16(1'b0, 16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, OVF_NEG_SUM});

    // 5a: back-to-back with start held high, incl. through RUN
    @(negedge clk);
    sub = 1'b0; a_in = 16'h0001; b_in = 16'h0002; cin = 1'b0; start = 1'b1;
    exp16_q.push_back({1'b0, 1'b0, 16'h0003});
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 40);
    check("b2b_first_done", {31'b0, done}, 32'd1);
    sub = 1'b0; a_in = 16'h1000; b_in = 16'h0234; cin = 1'b1;
    exp16_q.push_back({1'b0, 1'b0, 16'h1235});
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("b2b_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    check("b2b_done", {31'b0, done}, 32'd1);

    // 5b: reset in cycle 2 of RUN abandons the operation
    @(negedge clk);
    sub = 1'b0; a_in = 16'h4321; b_in = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_sum", {16'b0, sum}, 32'h0);
    check("mid_rst_cout", {31'b0, cout}, 32'd0);
    check("mid_rst_ovf", {31'b0, ovf}, 32'd0);
    check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue16(1'b0, 16'h4321, 16'h1111, 1'b0, {1'b0, 1'b0, 16'h5432});

    // 6: 8-bit sweep on CHUNK=1 and CHUNK=8
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 12; j++)
        for (int m = 0; m < 4; m++)
          issue8(m[1], vals[i], vals[j], m[0]);

    repeat (12) @(negedge clk);
    check("pending16", exp16_q.size(), 32'd0);
    check("pending_c1", exp8_c1_q.size(), 32'd0);
    check("pending_c8", exp8_c8_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
